sni_vc_packetizer: RTL and testbench
====================================

// Module: sni_vc_packetizer
// PURPOSE
//  Parametrised successor to the single-channel SNI pack stage. Turns NI-controller packet
//  requests plus payload words into HEAD/BODY/TAIL flits on NUM_VC virtual channels.
//  Uses per-VC credit flow control (replaces the 1-bit LinkC status) and a per-VC sequence
//  number stamped in the head flit. Sits between the SNI controller and the router local port.
// PARAMETERS
//  XY_WIDTH       4   width of one mesh coordinate
//  PAYLOAD_WIDTH  32  payload bits per flit; must be >= 4*XY_WIDTH+SN_WIDTH+LEN_WIDTH
//  NUM_VC         2   virtual channels (>=1); VC_W = max(1,$clog2(NUM_VC))
//  VC_DEPTH       4   router input buffer depth per VC = initial credits
//  SN_WIDTH       5   sequence-number width; wraps modulo 2^SN_WIDTH
//  LEN_WIDTH      4   payload-word count field width
// PORTS
//  clk            in   1                  clock
//  rst            in   1                  asynchronous, active-high reset
//  myx, myy       in   XY_WIDTH each      local coordinates; form the head src field {myx,myy}
//  pkt_valid      in   1                  packet request valid
//  pkt_ready      out  1                  request accepted when pkt_valid&&pkt_ready
//  pkt_vc         in   VC_W               target VC; values >= NUM_VC are illegal
//  pkt_dest       in   2*XY_WIDTH         {x,y} destination
//  pkt_len        in   LEN_WIDTH          number of payload words (0 = header-only)
//  pl_valid       in   1                  payload word valid
//  pl_ready       out  1                  payload word accepted when pl_valid&&pl_ready
//  pl_data        in   PAYLOAD_WIDTH      payload word
//  flit_valid     out  1                  flit_out valid this cycle (registered)
//  flit_out       out  2+VC_W+PAYLOAD_W   {type[1:0], vc, payload}
//  credit_ret     in   NUM_VC             1-cycle pulse per VC: one router slot freed
//  credit_err     out  1                  sticky: credit return while counter == VC_DEPTH
//  busy           out  1                  packet in progress (state != IDLE)
// BEHAVIOUR
//  Reset: state=IDLE; pkt_ready=1, pl_ready=0, flit_valid=0, flit_out=0, credit_err=0,
//   busy=0; every credit counter=VC_DEPTH; every SN=0.
//  Flit types: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, SINGLE=2'b11 (header-only packet).
//  Head payload, MSB-first: {dest, src, sn[vc], len}, zero-padded at the LSBs.
//  FSM:
//   IDLE: pkt_ready=1. On accept, latch vc/dest/len; go to HEAD.
//   HEAD: when credit[vc]>0, emit head (type SINGLE if len==0, else HEAD); decrement credit;
//    sn[vc]++ (wraps). Then go to IDLE if len==0, else to DATA with remaining=len.
//   DATA: pl_ready = (credit[vc]>0). Each accepted word is emitted as one flit;
//    remaining-- and credit[vc]--. Type is TAIL when remaining==1, else BODY.
//    After the TAIL flit, go to IDLE.
//  Latency: the flit for a handshake or head decision in cycle T appears at T+1.
//   flit_valid is high for exactly 1 cycle per flit. There is no back-pressure on flit_out.
//   Credits alone prevent router overflow. A new packet may be accepted in the cycle after
//   the TAIL/SINGLE decision.
//  Credit counters: width $clog2(VC_DEPTH+1).
//   Same-cycle consume and return on a VC -> net unchanged.
//   Return when counter==VC_DEPTH with no consume -> counter holds, credit_err set (sticky to reset).
//   Return is never lost when the counter is 0.
//  Credit stall: the FSM holds in HEAD/DATA with pl_ready=0 and flit_valid=0.
//   It resumes in the cycle after the credit arrives (counter>0).
//  Returns on other VCs are counted regardless of state.
//  Illegal pkt_vc (>=NUM_VC): request accepted and dropped; no flits, no SN change.
//  Async reset mid-packet: abort immediately, all state to reset values, no partial tail.
// STRUCTURE
//  Shared constants header: flit-type encodings, head-field offsets, FLIT_W macro.
//  Sub-module vc_credit_counter (one instance per VC via generate).
//   Ports: consume, ret, has_credit, overflow.
//  Top holds FSM, SN array, and the output register.
// TESTING (NUM_VC=2, VC_DEPTH=4, XY=4, SN=5, LEN=4, myx=1, myy=2)
//  1 len=3, vc=0, dest=(3,3), data A,B,C -> HEAD{33,12,sn0,3}, BODY A, BODY B, TAIL C.
//    Credit0 ends at 0; sn0=1.
//  2 len=0, vc=1 -> one SINGLE flit, vc=1; credit1=3; sn1=1; back in IDLE the next cycle.
//  3 vc0, len=5, no credit_ret -> 4 flits, then stall (pl_ready=0).
//    A credit_ret[0] pulse lets exactly one flit through per returned credit; TAIL last.
//  4 same-cycle consume + credit_ret on vc0 -> counter unchanged.
//    A credit_ret with counter=4 -> credit_err=1 and stays 1.
//  5 33 header-only packets on vc0 (credits recycled) -> SN sequence 0..31,0 (wrap).
//    sn1 stays unchanged.
//  6 assert rst during DATA of a len=4 packet -> flit_valid=0, busy=0, credits=4/4,
//    SNs=0 in the same cycle; the next packet starts at sn=0.

Source files
------------

// File: rtl/sni_vc_packetizer_pkg.sv
// -----------------------------------------------------------------------------
// sni_vc_packetizer_pkg
// Shared constants for the SNI virtual-channel packetizer:
//   - flit-type encodings carried in the two MSBs of every flit
//   - FSM state encoding
//   - width helpers for the VC field, the whole flit and the head fields
// -----------------------------------------------------------------------------
package sni_vc_packetizer_pkg;

  // Flit-type encodings
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_TAIL   = 2'b01;
  localparam logic [1:0] FLIT_HEAD   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;  // header-only packet

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // A single VC still needs a 1-bit field so the flit layout stays uniform.
  function automatic int vc_width(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  // Flit layout: {type[1:0], vc, payload}
  function automatic int flit_width(input int vc_w, input int payload_w);
    return 2 + vc_w + payload_w;
  endfunction

  // Head payload fields, MSB-first: {dest, src, sn, len}; remaining LSBs are zero.
  function automatic int head_fields_width(input int xy_w, input int sn_w, input int len_w);
    return 4 * xy_w + sn_w + len_w;
  endfunction

endpackage

// File: rtl/sni_vc_packetizer_vc_credit_counter.sv
// -----------------------------------------------------------------------------
// sni_vc_packetizer_vc_credit_counter
// Credit counter for one virtual channel. Starts at DEPTH (router buffer empty),
// decrements on every flit sent, increments on every credit returned.
//   clk, rst    clock, asynchronous active-high reset
//   consume     a flit is sent on this VC this cycle (only when has_credit)
//   ret         router returned one slot this cycle
//   has_credit  counter > 0
//   overflow    1-cycle flag: return while the counter is already full and
//               nothing is consumed (the return is discarded)
// -----------------------------------------------------------------------------
module sni_vc_packetizer_vc_credit_counter #(
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic consume,
  input  logic ret,
  output logic has_credit,
  output logic overflow
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] cnt_q;

  assign has_credit = (cnt_q != '0);
  assign overflow   = ret && !consume && (cnt_q == FULL);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= FULL;
    end else begin
      unique case ({consume, ret})
        2'b10:   cnt_q <= cnt_q - 1'b1;
        // A return at zero is always honoured; a return at full is dropped.
        2'b01:   if (cnt_q != FULL) cnt_q <= cnt_q + 1'b1;
        // Consume and return in the same cycle cancel out.
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sni_vc_packetizer.sv
// -----------------------------------------------------------------------------
// sni_vc_packetizer
// Turns NI-controller packet requests plus payload words into HEAD/BODY/TAIL
// (or SINGLE) flits on NUM_VC virtual channels, with per-VC credit flow control
// and a per-VC sequence number stamped into each head flit.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   myx, myy      local mesh coordinates (head src field)
//   pkt_valid/ready, pkt_vc, pkt_dest, pkt_len   packet request handshake
//   pl_valid/ready, pl_data                      payload word handshake
//   flit_valid, flit_out  registered flit output {type, vc, payload}; no stall
//   credit_ret    per-VC 1-cycle pulse: one router slot freed
//   credit_err    sticky: a credit came back while its counter was full
//   busy          a packet is in progress
// -----------------------------------------------------------------------------
module sni_vc_packetizer
  import sni_vc_packetizer_pkg::*;
#(
  parameter int XY_WIDTH      = 4,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int NUM_VC        = 2,
  parameter int VC_DEPTH      = 4,
  parameter int SN_WIDTH      = 5,
  parameter int LEN_WIDTH     = 4,
  localparam int VC_W         = vc_width(NUM_VC),
  localparam int FLIT_W       = flit_width(VC_W, PAYLOAD_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [XY_WIDTH-1:0]      myx,
  input  logic [XY_WIDTH-1:0]      myy,
  input  logic                     pkt_valid,
  output logic                     pkt_ready,
  input  logic [VC_W-1:0]          pkt_vc,
  input  logic [2*XY_WIDTH-1:0]    pkt_dest,
  input  logic [LEN_WIDTH-1:0]     pkt_len,
  input  logic                     pl_valid,
  output logic                     pl_ready,
  input  logic [PAYLOAD_WIDTH-1:0] pl_data,
  output logic                     flit_valid,
  output logic [FLIT_W-1:0]        flit_out,
  input  logic [NUM_VC-1:0]        credit_ret,
  output logic                     credit_err,
  output logic                     busy
);

  localparam int HEAD_W = head_fields_width(XY_WIDTH, SN_WIDTH, LEN_WIDTH);

  state_e                    state_q;
  logic [VC_W-1:0]           vc_q;
  logic [2*XY_WIDTH-1:0]     dest_q;
  logic [LEN_WIDTH-1:0]      len_q;
  logic [LEN_WIDTH-1:0]      remaining_q;
  logic [SN_WIDTH-1:0]       sn_q [NUM_VC];

  logic [NUM_VC-1:0]         consume;
  logic [NUM_VC-1:0]         has_credit;
  logic [NUM_VC-1:0]         overflow;
  logic                      cur_has_credit;
  logic                      vc_legal;
  logic                      head_fire;
  logic                      pl_fire;
  logic [PAYLOAD_WIDTH-1:0]  head_payload;

  // ---------------------------------------------------------------------------
  // Per-VC credit counters
  // ---------------------------------------------------------------------------
  for (genvar v = 0; v < NUM_VC; v++) begin : g_credit
    sni_vc_packetizer_vc_credit_counter #(
      .DEPTH (VC_DEPTH)
    ) u_credit (
      .clk        (clk),
      .rst        (rst),
      .consume    (consume[v]),
      .ret        (credit_ret[v]),
      .has_credit (has_credit[v]),
      .overflow   (overflow[v])
    );
  end

  // ---------------------------------------------------------------------------
  // Handshakes and credit consumption
  // ---------------------------------------------------------------------------
  // Compare in 32 bits so a power-of-two NUM_VC does not give a constant compare.
  assign vc_legal       = (32'(pkt_vc) < 32'(NUM_VC));
  assign cur_has_credit = has_credit[vc_q];
  assign head_fire      = (state_q == ST_HEAD) && cur_has_credit;
  assign pl_ready       = (state_q == ST_DATA) && cur_has_credit;
  assign pl_fire        = pl_valid && pl_ready;
  assign pkt_ready      = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);

  // NOTE: every combinational output gets a default before any conditional
  // update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    consume       = '0;
    consume[vc_q] = head_fire || pl_fire;
  end

  // Head fields packed against the payload MSB, zero-filled below.
  always_comb begin
    head_payload = '0;
    head_payload[PAYLOAD_WIDTH-1 -: HEAD_W] = {dest_q, myx, myy, sn_q[vc_q], len_q};
  end

  // ---------------------------------------------------------------------------
  // FSM, sequence numbers and the registered flit output
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vc_q        <= '0;
      dest_q      <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      flit_valid  <= 1'b0;
      flit_out    <= '0;
      credit_err  <= 1'b0;
      // NOTE: the SN array is protocol state (the receiver tracks it), so it
      // is reset like any other register rather than treated as storage.
      for (int v = 0; v < NUM_VC; v++) sn_q[v] <= '0;
    end else begin
      flit_valid <= 1'b0;
      credit_err <= credit_err | (|overflow);

      unique case (state_q)
        ST_IDLE: begin
          // Illegal VCs are accepted and silently dropped.
          if (pkt_valid && vc_legal) begin
            vc_q    <= pkt_vc;
            dest_q  <= pkt_dest;
            len_q   <= pkt_len;
            state_q <= ST_HEAD;
          end
        end

        ST_HEAD: begin
          if (head_fire) begin
            flit_valid  <= 1'b1;
            flit_out    <= {(len_q == '0) ? FLIT_SINGLE : FLIT_HEAD, vc_q, head_payload};
            sn_q[vc_q]  <= sn_q[vc_q] + 1'b1;
            remaining_q <= len_q;
            state_q     <= (len_q == '0) ? ST_IDLE : ST_DATA;
          end
        end

        ST_DATA: begin
          if (pl_fire) begin
            flit_valid  <= 1'b1;
            flit_out    <= {(remaining_q == LEN_WIDTH'(1)) ? FLIT_TAIL : FLIT_BODY,
                            vc_q, pl_data};
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == LEN_WIDTH'(1)) state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sni_vc_packetizer.sv
// -----------------------------------------------------------------------------
// tb_sni_vc_packetizer
// Self-checking bench: a directed packet table, hand-written credit corner
// cases, and randomized traffic scored against a packet-level reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sni_vc_packetizer;

  localparam int PW    = 32;
  localparam int NVC   = 2;
  localparam int DEPTH = 4;
  localparam int VCW   = 1;
  localparam int FW    = 2 + VCW + PW;

  localparam logic [3:0] MYX = 4'd1;
  localparam logic [3:0] MYY = 4'd2;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     myx, myy;
  logic           pkt_valid, pkt_ready;
  logic [VCW-1:0] pkt_vc;
  logic [7:0]     pkt_dest;
  logic [3:0]     pkt_len;
  logic           pl_valid, pl_ready;
  logic [PW-1:0]  pl_data;
  logic           flit_valid;
  logic [FW-1:0]  flit_out;
  logic [NVC-1:0] credit_ret;
  logic           credit_err;
  logic           busy;

  always #5 clk = ~clk;

  sni_vc_packetizer #(
    .XY_WIDTH(4), .PAYLOAD_WIDTH(PW), .NUM_VC(NVC), .VC_DEPTH(DEPTH),
    .SN_WIDTH(5), .LEN_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .myx(myx), .myy(myy),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_vc(pkt_vc),
    .pkt_dest(pkt_dest), .pkt_len(pkt_len),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .flit_valid(flit_valid), .flit_out(flit_out),
    .credit_ret(credit_ret), .credit_err(credit_err), .busy(busy)
  );

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  int             total = 0;
  int             bad   = 0;
  logic [FW-1:0]  exp_q[$];     // flits the model expects, in order
  logic [FW-1:0]  got_q[$];     // every flit observed
  int             used[NVC];    // router slots occupied per VC
  logic [4:0]     sn_m[NVC];    // next sequence number per VC
  logic           exp_err;
  bit             auto_ret;
  logic [NVC-1:0] force_ret;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  function automatic logic [FW-1:0] head_flit(input logic [VCW-1:0] vc, input logic [7:0] dest,
                                              input logic [4:0] sn, input logic [3:0] len);
    logic [PW-1:0] p;
    p = {dest, MYX, MYY, sn, len, 7'b0};
    return {(len == 4'd0) ? T_SINGLE : T_HEAD, vc, p};
  endfunction

  function automatic logic [4:0] sn_of(input logic [FW-1:0] f);
    return f[15:11];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int v = 0; v < NVC; v++) begin
      used[v] = 0;
      sn_m[v] = '0;
    end
    exp_err   = 1'b0;
    force_ret = '0;
  endtask

  // Score the outputs seen after a rising edge; r = credits returned at that edge.
  task automatic monitor(input logic [NVC-1:0] r);
    int             ub[NVC];
    logic           fv;
    logic [VCW-1:0] fvc;
    logic [FW-1:0]  e;
    for (int v = 0; v < NVC; v++) ub[v] = used[v];
    fv  = flit_valid;
    fvc = flit_out[PW +: VCW];
    if (fv) begin
      got_q.push_back(flit_out);
      check("credit_guard", 64'(used[fvc] < DEPTH), 64'd1);
      used[fvc]++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_flit: got=%0h expected=none", flit_out);
      end else begin
        e = exp_q.pop_front();
        check("flit", 64'(flit_out), 64'(e));
      end
    end
    for (int v = 0; v < NVC; v++) begin
      if (r[v]) begin
        if (ub[v] == 0 && !(fv && int'(fvc) == v)) exp_err = 1'b1;
        else used[v]--;
      end
    end
  endtask

  task automatic step();
    logic [NVC-1:0] r;
    r = force_ret;
    if (auto_ret)
      for (int v = 0; v < NVC; v++)
        if (used[v] > 0 && $urandom_range(0, 2) == 0) r[v] = 1'b1;
    credit_ret = r;
    @(posedge clk);
    @(negedge clk);
    monitor(r);
    credit_ret = '0;
    force_ret  = '0;
  endtask

  task automatic start_pkt(input logic [VCW-1:0] vc, input logic [7:0] dest, input logic [3:0] len);
    bit ok, rdy;
    ok = 0;
    pkt_valid = 1'b1; pkt_vc = vc; pkt_dest = dest; pkt_len = len;
    for (int i = 0; i < 50; i++) begin
      rdy = pkt_ready;
      step();
      if (rdy) begin ok = 1; break; end
    end
    pkt_valid = 1'b0;
    if (!ok) timeout("pkt_accept");
    exp_q.push_back(head_flit(vc, dest, sn_m[vc], len));
    sn_m[vc] = sn_m[vc] + 5'd1;
  endtask

  task automatic push_word(input logic [VCW-1:0] vc, input logic [PW-1:0] d, input bit last);
    bit ok, rdy;
    ok = 0;
    pl_valid = 1'b1; pl_data = d;
    exp_q.push_back({last ? T_TAIL : T_BODY, vc, d});
    for (int i = 0; i < 60; i++) begin
      rdy = pl_ready;
      step();
      if (rdy) begin ok = 1; break; end
    end
    pl_valid = 1'b0;
    if (!ok) timeout("pl_accept");
  endtask

  task automatic send_pkt(input logic [VCW-1:0] vc, input logic [7:0] dest, input logic [3:0] len,
                          input logic [PW-1:0] base, input bit gaps);
    start_pkt(vc, dest, len);
    for (int i = 0; i < int'(len); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      push_word(vc, base + PW'(i), i == int'(len) - 1);
    end
  endtask

  task automatic wait_flits(input int n);
    for (int i = 0; i < 200 && got_q.size() < n; i++) step();
    if (got_q.size() < n) timeout("wait_flits");
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      for (int v = 0; v < NVC; v++) force_ret[v] = (used[v] > 0);
      if (force_ret == '0) break;
      step();
    end
  endtask

  task automatic apply_reset();
    auto_ret = 0;
    pkt_valid = 1'b0; pl_valid = 1'b0; credit_ret = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Directed packet table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [VCW-1:0] vc;
    logic [7:0]     dest;
    logic [3:0]     len;
    logic [PW-1:0]  base;
    int             nflits;
    logic [1:0]     htype;
    logic [4:0]     hsn;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int            n0;
    logic [FW-1:0] f;

    tbl[0] = '{1'b0, 8'h33, 4'd3, 32'h0000_000A, 4, T_HEAD,   5'd0};
    tbl[1] = '{1'b1, 8'h00, 4'd0, 32'h0,         1, T_SINGLE, 5'd0};
    tbl[2] = '{1'b1, 8'hF5, 4'd1, 32'hDEAD_0000, 2, T_HEAD,   5'd1};
    tbl[3] = '{1'b0, 8'h7A, 4'd0, 32'h0,         1, T_SINGLE, 5'd1};
    tbl[4] = '{1'b0, 8'h21, 4'd2, 32'h5555_0000, 3, T_HEAD,   5'd2};

    myx = MYX; myy = MYY;
    pkt_valid = 1'b0; pkt_vc = '0; pkt_dest = '0; pkt_len = '0;
    pl_valid = 1'b0; pl_data = '0; credit_ret = '0;
    auto_ret = 0;
    model_reset();

    // Reset state
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_pkt_ready",  64'(pkt_ready),  64'd1);
    check("rst_pl_ready",   64'(pl_ready),   64'd0);
    check("rst_flit_valid", 64'(flit_valid), 64'd0);
    check("rst_flit_out",   64'(flit_out),   64'd0);
    check("rst_credit_err", 64'(credit_err), 64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: each packet with full credits, then the router frees its slots
    for (int e = 0; e < 5; e++) begin
      n0 = got_q.size();
      send_pkt(tbl[e].vc, tbl[e].dest, tbl[e].len, tbl[e].base, 1'b0);
      wait_flits(n0 + tbl[e].nflits);
      check("idle_after", 64'({pkt_ready, busy}), 64'(2'b10));
      step();
      step();
      check("nflits", 64'(got_q.size() - n0), 64'(tbl[e].nflits));
      f = (got_q.size() > n0) ? got_q[n0] : '0;
      check("head_type", 64'(f[FW-1 -: 2]), 64'(tbl[e].htype));
      check("head_sn",   64'(sn_of(f)),     64'(tbl[e].hsn));
      drain();
    end

    // Credit stall: len=5 on vc0 with four credits and no returns
    start_pkt(1'b0, 8'h44, 4'd5);
    for (int i = 0; i < 3; i++) push_word(1'b0, 32'h3000 + 32'(i), 1'b0);
    pl_valid = 1'b1; pl_data = 32'h3003;
    exp_q.push_back({T_BODY, 1'b0, 32'h3003});
    repeat (3) step();
    check("stall_pl_ready", 64'(pl_ready),   64'd0);
    check("stall_no_flit",  64'(flit_valid), 64'd0);
    check("stall_busy",     64'(busy),       64'd1);
    force_ret[0] = 1'b1;
    step();
    check("resume_pl_ready", 64'(pl_ready), 64'd1);
    step();
    check("one_per_credit", 64'(pl_ready), 64'd0);
    pl_data = 32'h3004;
    exp_q.push_back({T_TAIL, 1'b0, 32'h3004});
    force_ret[0] = 1'b1;
    step();
    step();
    pl_valid = 1'b0;
    check("tail_idle", 64'(pkt_ready), 64'd1);
    drain();

    // Same-cycle consume and return, then a return into a full counter
    start_pkt(1'b0, 8'h55, 4'd1);
    force_ret[0] = 1'b1;
    step();
    check("same_cycle_no_err", 64'(credit_err), 64'd0);
    push_word(1'b0, 32'h4000, 1'b1);
    drain();
    check("full_no_err", 64'(credit_err), 64'd0);
    force_ret[0] = 1'b1;
    step();
    check("credit_err_set", 64'(credit_err), 64'd1);
    repeat (3) step();
    check("credit_err_sticky", 64'(credit_err), 64'(exp_err));

    // SN wrap: 33 header-only packets on vc0, credits recycled
    apply_reset();
    auto_ret = 1;
    for (int k = 0; k < 33; k++) begin
      n0 = got_q.size();
      send_pkt(1'b0, 8'h66, 4'd0, 32'h0, 1'b0);
      wait_flits(n0 + 1);
      f = (got_q.size() > n0) ? got_q[n0] : '0;
      check("sn_wrap", 64'(sn_of(f)), 64'(k % 32));
    end
    n0 = got_q.size();
    send_pkt(1'b1, 8'h66, 4'd0, 32'h0, 1'b0);
    wait_flits(n0 + 1);
    f = (got_q.size() > n0) ? got_q[n0] : '0;
    check("sn1_unchanged", 64'(sn_of(f)), 64'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 40; k++)
      send_pkt(1'($urandom_range(0, NVC - 1)), 8'($urandom), 4'($urandom_range(0, 15)),
               $urandom, 1'b1);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("random_no_err", 64'(credit_err), 64'd0);

    // Asynchronous reset in the middle of a len=4 packet
    apply_reset();
    start_pkt(1'b0, 8'h77, 4'd4);
    push_word(1'b0, 32'h6000, 1'b0);
    push_word(1'b0, 32'h6001, 1'b0);
    check("mid_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_flit_valid", 64'(flit_valid), 64'd0);
    check("abort_busy",       64'(busy),       64'd0);
    check("abort_pkt_ready",  64'(pkt_ready),  64'd1);
    check("abort_pl_ready",   64'(pl_ready),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n0 = got_q.size();
    send_pkt(1'b0, 8'h88, 4'd3, 32'h7000, 1'b0);
    send_pkt(1'b1, 8'h99, 4'd3, 32'h8000, 1'b0);
    wait_flits(n0 + 8);
    f = (got_q.size() > n0) ? got_q[n0] : '0;
    check("post_rst_sn0", 64'(sn_of(f)), 64'd0);
    f = (got_q.size() > n0 + 4) ? got_q[n0 + 4] : '0;
    check("post_rst_sn1", 64'(sn_of(f)), 64'd0);
    check("post_rst_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
